// File: rtl/mem_alu_sequencer_if.sv
// Command handshake and host RAM bus for mem_alu_sequencer.
// The host drives the master side; the sequencer implements the slave side.
interface mem_alu_sequencer_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8
);
   logic              start;
   logic [2:0]        op;
   logic [ADDR_W-1:0] addr_a;
   logic [ADDR_W-1:0] addr_b;
   logic [ADDR_W-1:0] addr_d;
   logic              busy;
   logic              done;
   logic              err;
   logic              ext_we;
   logic [ADDR_W-1:0] ext_addr;
   logic [DATA_W-1:0] ext_wdata;
   logic [DATA_W-1:0] ext_rdata;

   modport master (
      output start, op, addr_a, addr_b, addr_d, ext_we, ext_addr, ext_wdata,
      input  busy, done, err, ext_rdata
   );

   modport slave (
      input  start, op, addr_a, addr_b, addr_d, ext_we, ext_addr, ext_wdata,
      output busy, done, err, ext_rdata
   );
endinterface

// File: rtl/mem_alu_sequencer.sv
// Word RAM + register file + ALU sequenced as mem[d] <= mem[a] OP mem[b] per command.
// Optional macro ALU_OVF_TRAP_EN: ADD/SUB overflow suppresses the RAM write and pulses err.
module mem_alu_sequencer #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8,
   parameter int REG_AW = 3
) (
   input  logic                 clk_m,
   input  logic                 Reset,
   mem_alu_sequencer_if.slave   bus,
   input  logic [REG_AW-1:0]    dbg_ra,
   input  logic [REG_AW-1:0]    dbg_rb,
   output logic [DATA_W-1:0]    Data_A,
   output logic [DATA_W-1:0]    Data_B,
   output logic [DATA_W-1:0]    result,
   output logic                 zero,
   output logic                 ovf,
   output logic [7:0]           LED
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam int NREG  = 2 ** REG_AW;

   typedef enum logic [2:0] {
      OP_AND = 3'b000, OP_OR  = 3'b001, OP_ADD = 3'b010, OP_XOR = 3'b011,
      OP_NOR = 3'b100, OP_SLL = 3'b101, OP_SUB = 3'b110, OP_SLT = 3'b111
   } alu_op_t;

   typedef enum logic [2:0] {
      S_IDLE, S_RD_A, S_RD_B, S_CAP_B, S_EXEC, S_WR, S_DONE
   } state_t;

   typedef struct packed {
      alu_op_t           op;
      logic [ADDR_W-1:0] a;
      logic [ADDR_W-1:0] b;
      logic [ADDR_W-1:0] d;
   } cmd_t;

   state_t            state_q, state_d;
   cmd_t              cmd_q;
   logic              cmd_load;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] regs_q [NREG];
   logic              zero_q, ovf_q;

   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_we;
   logic              wr_allow;
   logic              busy, done;

   logic [DATA_W-1:0] alu_a, alu_b, alu_sum, alu_diff, alu_res;
   logic              alu_ovf;

`ifdef ALU_OVF_TRAP_EN
   assign wr_allow = !ovf_q;
   assign bus.err  = done && ovf_q;
`else
   assign wr_allow = 1'b1;
   assign bus.err  = 1'b0;
`endif

   always_ff @(posedge clk_m or posedge Reset) begin
      if (Reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      busy      = 1'b0;
      done      = 1'b0;
      cmd_load  = 1'b0;
      ram_addr  = bus.ext_addr;
      ram_wdata = bus.ext_wdata;
      ram_we    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            ram_we = bus.ext_we;
            if (bus.start) begin
               cmd_load = 1'b1;
               state_d  = S_RD_A;
            end
         end
         S_RD_A: begin
            busy     = 1'b1;
            ram_addr = cmd_q.a;
            state_d  = S_RD_B;
         end
         S_RD_B: begin
            busy     = 1'b1;
            ram_addr = cmd_q.b;
            state_d  = S_CAP_B;
         end
         S_CAP_B: begin
            busy    = 1'b1;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            busy    = 1'b1;
            state_d = S_WR;
         end
         S_WR: begin
            busy      = 1'b1;
            ram_addr  = cmd_q.d;
            ram_wdata = regs_q[3];
            ram_we    = wr_allow;
            state_d   = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.busy = busy;
   assign bus.done = done;

   assign alu_a    = regs_q[1];
   assign alu_b    = regs_q[2];
   assign alu_sum  = alu_a + alu_b;
   assign alu_diff = alu_a - alu_b;

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      unique case (cmd_q.op)
         OP_AND: alu_res = alu_a & alu_b;
         OP_OR:  alu_res = alu_a | alu_b;
         OP_ADD: begin
            alu_res = alu_sum;
            alu_ovf = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) && (alu_sum[DATA_W-1] != alu_a[DATA_W-1]);
         end
         OP_XOR: alu_res = alu_a ^ alu_b;
         OP_NOR: alu_res = ~(alu_a | alu_b);
         OP_SLL: alu_res = alu_a << alu_b[4:0];
         OP_SUB: begin
            alu_res = alu_diff;
            alu_ovf = (alu_a[DATA_W-1] != alu_b[DATA_W-1]) && (alu_diff[DATA_W-1] != alu_a[DATA_W-1]);
         end
         OP_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
         default: alu_res = '0;
      endcase
   end

   // NOTE: the RAM array has no reset; clearing it would prevent block-RAM mapping.
   always_ff @(posedge clk_m) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
   end

   // Read-before-write: the port returns the old word when it is written in the same cycle.
   always_ff @(posedge clk_m or posedge Reset) begin
      if (Reset) begin
         cmd_q   <= '0;
         rdata_q <= '0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else begin
         rdata_q <= mem[ram_addr];
         if (cmd_load)
            cmd_q <= '{op: alu_op_t'(bus.op), a: bus.addr_a, b: bus.addr_b, d: bus.addr_d};
         if (state_q == S_RD_B)  regs_q[1] <= rdata_q;
         if (state_q == S_CAP_B) regs_q[2] <= rdata_q;
         if (state_q == S_EXEC) begin
            regs_q[3] <= alu_res;
            zero_q    <= (alu_res == '0);
            ovf_q     <= alu_ovf;
         end
      end
   end

   assign bus.ext_rdata = rdata_q;
   assign Data_A        = (dbg_ra == '0) ? '0 : regs_q[dbg_ra];
   assign Data_B        = (dbg_rb == '0) ? '0 : regs_q[dbg_rb];
   assign result        = regs_q[3];
   assign zero          = zero_q;
   assign ovf           = ovf_q;
   assign LED           = regs_q[3][7:0];
endmodule

// File: tb/tb_mem_alu_sequencer.sv
// Self-checking bench for mem_alu_sequencer: directed scenarios then randomized commands
// checked against an arithmetic reference model of the RAM and the ALU.
module tb_mem_alu_sequencer;
   localparam int     DATA_W = 32;
   localparam int     ADDR_W = 8;
   localparam int     REG_AW = 3;
   localparam longint SMAX   = 64'sd2147483647;
   localparam longint SMIN   = -64'sd2147483648;
   localparam logic [7:0] JUNK_ADDR = 8'd200;

   logic clk_m = 1'b0;
   logic Reset = 1'b1;
   logic [REG_AW-1:0] dbg_ra = '0, dbg_rb = '0;
   logic [DATA_W-1:0] Data_A, Data_B, result;
   logic zero, ovf;
   logic [7:0] LED;

   mem_alu_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   mem_alu_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_AW(REG_AW)) dut (
      .clk_m (clk_m),
      .Reset (Reset),
      .bus   (bus),
      .dbg_ra(dbg_ra),
      .dbg_rb(dbg_rb),
      .Data_A(Data_A),
      .Data_B(Data_B),
      .result(result),
      .zero  (zero),
      .ovf   (ovf),
      .LED   (LED)
   );

   always #5 clk_m = ~clk_m;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   logic [DATA_W-1:0] mem_m [256];

   task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
      n_checks = n_checks + 1;
      assert (got === exp) n_pass = n_pass + 1;
      else begin
         n_fail = n_fail + 1;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic void ref_alu(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output bit v);
      longint sa, sb, s;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      v  = 1'b0;
      case (o)
         3'd0: r = a & b;
         3'd1: r = a | b;
         3'd2: begin s = sa + sb; r = s[31:0]; v = (s > SMAX) || (s < SMIN); end
         3'd3: r = a ^ b;
         3'd4: r = ~(a | b);
         3'd5: r = a << b[4:0];
         3'd6: begin s = sa - sb; r = s[31:0]; v = (s > SMAX) || (s < SMIN); end
         default: r = (sa < sb) ? 32'd1 : 32'd0;
      endcase
   endfunction

   task automatic host_write(input logic [7:0] a, input logic [31:0] d);
      bus.ext_we    = 1'b1;
      bus.ext_addr  = a;
      bus.ext_wdata = d;
      mem_m[a]      = d;
      @(negedge clk_m);
      bus.ext_we    = 1'b0;
   endtask

   task automatic host_read(input logic [7:0] a, output logic [31:0] d);
      bus.ext_addr = a;
      @(negedge clk_m);
      d = bus.ext_rdata;
   endtask

   task automatic run_cmd(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] d, input bit with_ext, input logic [7:0] ext_a,
                          input logic [31:0] ext_d, input bit intrude);
      logic [31:0] va, vb, res, rd;
      bit v, trap, seen;
      int lat;
      bus.op = o; bus.addr_a = a; bus.addr_b = b; bus.addr_d = d;
      bus.start = 1'b1;
      if (with_ext) begin
         bus.ext_we = 1'b1; bus.ext_addr = ext_a; bus.ext_wdata = ext_d;
         mem_m[ext_a] = ext_d;
      end
      va = mem_m[a];
      vb = mem_m[b];
      ref_alu(o, va, vb, res, v);
      trap = 1'b0;
`ifdef ALU_OVF_TRAP_EN
      trap = v;
`endif
      @(negedge clk_m);
      bus.start = 1'b0; bus.ext_we = 1'b0;
      check("busy_after_start", bus.busy, 1);
      seen = 1'b0; lat = 0;
      for (int k = 1; k <= 12 && !seen; k++) begin
         if (intrude && k == 1) begin
            bus.start = 1'b1; bus.op = ~o; bus.addr_d = JUNK_ADDR;
            bus.ext_we = 1'b1; bus.ext_addr = JUNK_ADDR; bus.ext_wdata = 32'h0BAD_0BAD;
         end
         @(negedge clk_m);
         bus.start = 1'b0; bus.ext_we = 1'b0;
         if (bus.done) begin seen = 1'b1; lat = k; end
      end
      check("done_seen", 32'(seen), 1);
      check("latency", lat, 5);
      check("busy_at_done", bus.busy, 0);
      check("err_at_done", bus.err, 32'(trap));
      if (intrude) begin
         bus.start = 1'b1; bus.ext_we = 1'b1;
         bus.ext_addr = JUNK_ADDR; bus.ext_wdata = 32'h0BAD_0BAD;
      end
      @(negedge clk_m);
      bus.start = 1'b0; bus.ext_we = 1'b0;
      check("done_one_cycle", bus.done, 0);
      check("idle_after_done", bus.busy, 0);
      if (!trap) mem_m[d] = res;
      check("result", result, res);
      check("led", LED, res[7:0]);
      check("zero", zero, 32'(res == 32'd0));
      check("ovf", ovf, 32'(v));
      dbg_ra = 3'd3; dbg_rb = 3'd1;
      #1;
      check("data_a_r3", Data_A, res);
      check("data_b_r1", Data_B, va);
      dbg_ra = 3'd0; dbg_rb = 3'd2;
      #1;
      check("data_a_r0", Data_A, 0);
      check("data_b_r2", Data_B, vb);
      host_read(d, rd);
      check("ram_dest", rd, mem_m[d]);
      if (intrude) begin
         host_read(JUNK_ADDR, rd);
         check("ram_untouched", rd, mem_m[JUNK_ADDR]);
      end
   endtask

   initial begin : main
      logic [31:0] rd;
      int dones;
      bus.start = 1'b0; bus.op = '0; bus.addr_a = '0; bus.addr_b = '0; bus.addr_d = '0;
      bus.ext_we = 1'b0; bus.ext_addr = '0; bus.ext_wdata = '0;

      // Reset state
      repeat (2) @(negedge clk_m);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_err", bus.err, 0);
      check("rst_zero", zero, 0);
      check("rst_ovf", ovf, 0);
      check("rst_result", result, 0);
      check("rst_led", LED, 0);
      check("rst_rdata", bus.ext_rdata, 0);
      Reset = 1'b0;
      @(negedge clk_m);

      for (int i = 0; i < 16; i++) host_write(8'(i), $urandom);
      host_write(JUNK_ADDR, 32'hDEAD_BEEF);

      // Reset during RD_B aborts the command
      host_write(8'd9, 32'h1234_5678);
      bus.op = 3'd2; bus.addr_a = 8'd1; bus.addr_b = 8'd2; bus.addr_d = 8'd9;
      bus.start = 1'b1;
      @(negedge clk_m);
      bus.start = 1'b0;
      @(negedge clk_m);
      Reset = 1'b1;
      dbg_ra = 3'd1; dbg_rb = 3'd2;
      #1;
      check("abort_busy", bus.busy, 0);
      check("abort_r1", Data_A, 0);
      check("abort_r2", Data_B, 0);
      check("abort_r3", result, 0);
      @(negedge clk_m);
      Reset = 1'b0;
      dones = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk_m);
         if (bus.done || bus.busy) dones++;
      end
      check("abort_no_done", dones, 0);
      host_read(8'd9, rd);
      check("abort_ram_kept", rd, mem_m[9]);

      // Directed ALU scenarios
      host_write(8'd1, 32'd5);
      host_write(8'd2, 32'd3);
      run_cmd(3'd2, 8'd1, 8'd2, 8'd3, 0, 8'd0, 32'd0, 0);
      run_cmd(3'd6, 8'd2, 8'd1, 8'd4, 0, 8'd0, 32'd0, 0);
      run_cmd(3'd7, 8'd2, 8'd1, 8'd10, 0, 8'd0, 32'd0, 0);
      host_write(8'd1, 32'h7FFF_FFFF);
      host_write(8'd2, 32'd1);
      host_write(8'd5, 32'h5555_AAAA);
      run_cmd(3'd2, 8'd1, 8'd2, 8'd5, 0, 8'd0, 32'd0, 0);
      host_write(8'd2, 32'd3);
      run_cmd(3'd0, 8'd1, 8'd2, 8'd8, 1, 8'd1, 32'd9, 1);
      host_write(8'd6, 32'd4);
      host_write(8'd7, 32'd1);
      run_cmd(3'd1, 8'd6, 8'd7, 8'd6, 0, 8'd0, 32'd0, 0);

      // Randomized commands
      for (int i = 0; i < 24; i++) begin
         logic [31:0] pick;
         for (int j = 0; j < 2; j++) begin
            case ($urandom_range(0, 5))
               0: pick = 32'h0;
               1: pick = 32'h7FFF_FFFF;
               2: pick = 32'h8000_0000;
               3: pick = 32'hFFFF_FFFF;
               default: pick = $urandom;
            endcase
            host_write(8'($urandom_range(0, 15)), pick);
         end
         run_cmd(3'($urandom_range(0, 7)), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                 8'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                 8'($urandom_range(0, 15)), $urandom, (i % 4 == 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
